decode_issue_ctrl: RTL and testbench

// Single-entry decode/issue controller between fetch and execute. Latches one fetched instruction,

---
 rtl/decode_issue_ctrl_if.sv | 31 +++
 rtl/decode_issue_ctrl.sv | 103 ++++++++++
 tb/tb_decode_issue_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_issue_ctrl_if.sv
// Fetch / issue / writeback signal bundle for decode_issue_ctrl.
// master = surrounding pipeline (fetch, execute, writeback), slave = the controller.
interface decode_issue_ctrl_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic             instr_valid_i;
  logic [31:0]      instr_i;
  logic [XLEN-1:0]  instr_pc_i;
  logic             instr_ready_o;
  logic             flush_i;
  logic             issue_valid_o;
  logic             issue_ready_i;
  logic [31:0]      issue_instr_o;
  logic [XLEN-1:0]  issue_pc_o;
  logic             wb_valid_i;
  logic [4:0]       wb_rd_i;
  logic [31:0]      busy_regs_o;
  logic             stall_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output instr_valid_i, instr_i, instr_pc_i, flush_i, issue_ready_i, wb_valid_i, wb_rd_i,
    input  instr_ready_o, issue_valid_o, issue_instr_o, issue_pc_o, busy_regs_o, stall_o, stall_cnt_o
  );

  modport slave (
    input  instr_valid_i, instr_i, instr_pc_i, flush_i, issue_ready_i, wb_valid_i, wb_rd_i,
    output instr_ready_o, issue_valid_o, issue_instr_o, issue_pc_o, busy_regs_o, stall_o, stall_cnt_o
  );
endinterface

// File: rtl/decode_issue_ctrl.sv
// Single-entry decode/issue controller with a 32-entry in-flight destination scoreboard.
// Optional macro DECODE_WB_BYPASS_EN: hazard check ignores a register retiring this same cycle.
module decode_issue_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input logic                clk,
  input logic                resetn,
  decode_issue_ctrl_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, HOLD, STALL} state_t;
  typedef struct packed { logic rs1; logic rs2; logic rd; } usage_t;
  typedef struct packed { logic [31:0] instr; logic [XLEN-1:0] pc; } slot_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t           state_q, state_d;
  slot_t            slot_q;
  usage_t           use_h;
  logic [31:0]      busy_q, busy_chk, wb_mask, set_mask;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [4:0]       rs1, rs2, rd;
  logic             hazard, offer, stall, fire, ready, accept;

  always_comb begin
    use_h = '0;
    case (slot_q.instr[6:0])
      OP_R:                      use_h = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b1};
      OP_IMM, OP_LOAD, OP_JALR:  use_h = '{rs1: 1'b1, rs2: 1'b0, rd: 1'b1};
      OP_STORE, OP_BR:           use_h = '{rs1: 1'b1, rs2: 1'b1, rd: 1'b0};
      OP_LUI, OP_AUIPC, OP_JAL:  use_h = '{rs1: 1'b0, rs2: 1'b0, rd: 1'b1};
      default:                   use_h = '0;
    endcase
  end

  assign rs1 = slot_q.instr[19:15];
  assign rs2 = slot_q.instr[24:20];
  assign rd  = slot_q.instr[11:7];

  assign wb_mask = bus.wb_valid_i ? (32'd1 << bus.wb_rd_i) : 32'd0;
`ifdef DECODE_WB_BYPASS_EN
  assign busy_chk = busy_q & ~wb_mask;
`else
  assign busy_chk = busy_q;
`endif

  // busy[0] is never set, so x0 operands can never raise a hazard
  assign hazard = (use_h.rs1 & busy_chk[rs1]) | (use_h.rs2 & busy_chk[rs2]) | (use_h.rd & busy_chk[rd]);
  assign offer  = (state_q == HOLD) & ~hazard;
  assign stall  = (state_q == STALL) | ((state_q == HOLD) & hazard);
  assign fire   = offer & bus.issue_ready_i & ~bus.flush_i;
  assign ready  = ~bus.flush_i & ((state_q == EMPTY) | fire);
  assign accept = bus.instr_valid_i & ready;

  assign set_mask = (fire & use_h.rd & (rd != 5'd0)) ? (32'd1 << rd) : 32'd0;

  always_comb begin
    state_d = state_q;
    if (bus.flush_i) state_d = EMPTY;
    else begin
      case (state_q)
        EMPTY: if (accept) state_d = HOLD;
        HOLD: begin
          if (fire)        state_d = accept ? HOLD : EMPTY;
          else if (hazard) state_d = STALL;
        end
        STALL:   if (!hazard) state_d = HOLD;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= EMPTY;
      slot_q      <= '0;
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) slot_q <= '{instr: bus.instr_i, pc: bus.instr_pc_i};
      // set after clear: a destination re-issued while its old write retires stays busy
      busy_q <= (busy_q & ~wb_mask) | set_mask;
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.instr_ready_o = ready;
  assign bus.issue_valid_o = offer;
  assign bus.issue_instr_o = slot_q.instr;
  assign bus.issue_pc_o    = slot_q.pc;
  assign bus.busy_regs_o   = busy_q;
  assign bus.stall_o       = stall;
  assign bus.stall_cnt_o   = stall_cnt_q;
endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: directed table, hand sequences and random traffic
// checked every cycle against an occupancy/scoreboard reference model.
module tb_decode_issue_ctrl;
  localparam int XLEN    = 64;
  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [31:0] ADD_X5 = 32'h002082B3;  // add x5,x1,x2
  localparam logic [31:0] SUB_X6 = 32'h40328333;  // sub x6,x5,x3
  localparam logic [31:0] LUI_X7 = 32'h000003B7;  // lui x7,0
  localparam logic [31:0] ADDI_7 = 32'h00100393;  // addi x7,x0,1
  localparam logic [31:0] NOP    = 32'h00000013;  // addi x0,x0,0

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  decode_issue_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();
  decode_issue_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int checks = 0;
  int errors = 0;

  // reference model: is an instruction held, is it parked in stall, scoreboard, counter
  bit              m_held, m_stalled;
  logic [31:0]     m_instr, m_busy;
  logic [XLEN-1:0] m_pc;
  int              m_cnt;

  typedef struct {
    logic             ivalid, iready, stall;
    logic [31:0]      busy, instr;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  typedef struct {
    bit iv; logic [31:0] ins; bit rdy; bit wbv; logic [4:0] wbrd;
    bit e_v; bit e_r; bit e_s; logic [31:0] e_busy; int e_cnt;
  } vec_t;

  function automatic logic [2:0] usage(input logic [6:0] op);  // {rs1, rs2, rd}
    case (op)
      7'b0110011:                         return 3'b111;
      7'b0010011, 7'b0000011, 7'b1100111: return 3'b101;
      7'b0100011, 7'b1100011:             return 3'b110;
      7'b0110111, 7'b0010111, 7'b1101111: return 3'b001;
      default:                            return 3'b000;
    endcase
  endfunction

  function automatic logic [31:0] enc_i(input int rdn, input int rs, input int imm);
    return (32'(imm) << 20) | (32'(rs) << 15) | (32'(rdn) << 7) | 32'h13;
  endfunction

  function automatic bit m_hazard(input bit wbv, input logic [4:0] wbrd);
    logic [31:0] b;
    logic [2:0]  u;
    b = m_busy;
`ifdef DECODE_WB_BYPASS_EN
    if (wbv) b[wbrd] = 1'b0;
`endif
    u = usage(m_instr[6:0]);
    return (u[2] && b[m_instr[19:15]]) || (u[1] && b[m_instr[24:20]]) || (u[0] && b[m_instr[11:7]]);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_held = 0; m_stalled = 0; m_instr = '0; m_pc = '0; m_busy = '0; m_cnt = 0;
  endtask

  // one clock: drive at negedge, compare settled outputs with the model, then advance the model
  task automatic step(input bit iv, input logic [31:0] ins, input bit rdy, input bit fl,
                      input bit wbv, input logic [4:0] wbrd, output obs_t o);
    bit haz, ev, es, er, fire;
    logic [2:0] u;
    logic [XLEN-1:0] pc;
    @(negedge clk);
    pc = XLEN'($urandom) << 2;
    bus.instr_valid_i = iv;  bus.instr_i = ins;  bus.instr_pc_i = pc;
    bus.issue_ready_i = rdy; bus.flush_i = fl;
    bus.wb_valid_i = wbv;    bus.wb_rd_i = wbrd;
    #1;
    haz  = m_hazard(wbv, wbrd);
    ev   = m_held && !m_stalled && !haz;
    es   = m_held && (m_stalled || haz);
    fire = ev && rdy && !fl;
    er   = !fl && (!m_held || fire);
    o.ivalid = bus.issue_valid_o; o.iready = bus.instr_ready_o; o.stall = bus.stall_o;
    o.busy = bus.busy_regs_o; o.instr = bus.issue_instr_o; o.cnt = bus.stall_cnt_o;
    chk("issue_valid", o.ivalid, ev);
    chk("instr_ready", o.iready, er);
    chk("stall", o.stall, es);
    chk("busy_regs", o.busy, m_busy);
    chk("stall_cnt", o.cnt, m_cnt);
    chk("issue_instr", o.instr, m_instr);
    chk("issue_pc", bus.issue_pc_o, m_pc);
    u = usage(m_instr[6:0]);
    if (wbv) m_busy[wbrd] = 1'b0;
    if (fire && u[0] && m_instr[11:7] != 5'd0) m_busy[m_instr[11:7]] = 1'b1;
    if (es && m_cnt < CNT_MAX) m_cnt++;
    if (fl) m_held = 0;
    else if (iv && er) begin m_held = 1; m_stalled = 0; m_instr = ins; m_pc = pc; end
    else if (fire) m_held = 0;
    else if (m_held) m_stalled = haz;
  endtask

  task automatic idle(input bit rdy, output obs_t o);
    step(1'b0, 32'h0, rdy, 1'b0, 1'b0, 5'd0, o);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.instr_valid_i = 0; bus.issue_ready_i = 0; bus.flush_i = 0; bus.wb_valid_i = 0;
    #1 resetn = 1'b0;
    #1;
    chk("rst_issue_valid", bus.issue_valid_o, 0);
    chk("rst_instr_ready", bus.instr_ready_o, 1);
    chk("rst_busy", bus.busy_regs_o, 0);
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_stall_cnt", bus.stall_cnt_o, 0);
    chk("rst_issue_instr", bus.issue_instr_o, 0);
    chk("rst_issue_pc", bus.issue_pc_o, 0);
    m_reset();
    #1 resetn = 1'b1;
  endtask

  vec_t tv[8];
  logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};

  initial begin
    obs_t o;
    logic [31:0] ins, busy_before;
    bus.instr_valid_i = 0; bus.instr_i = '0; bus.instr_pc_i = '0; bus.issue_ready_i = 0;
    bus.flush_i = 0; bus.wb_valid_i = 0; bus.wb_rd_i = '0;
    m_reset();
    do_reset();

    // RAW: add x5 then dependent sub x6, released by writeback of x5
    tv[0] = '{1, ADD_X5, 1, 0, 5'd0, 0, 1, 0, 32'h0,  0};
    tv[1] = '{1, SUB_X6, 1, 0, 5'd0, 1, 1, 0, 32'h0,  0};
    tv[2] = '{0, 32'h0,  1, 0, 5'd0, 0, 0, 1, 32'h20, 0};
    tv[3] = '{0, 32'h0,  1, 0, 5'd0, 0, 0, 1, 32'h20, 1};
    tv[4] = '{0, 32'h0,  1, 1, 5'd5, 0, 0, 1, 32'h20, 2};
`ifdef DECODE_WB_BYPASS_EN
    tv[5] = '{0, 32'h0,  1, 0, 5'd0, 1, 1, 0, 32'h0,  3};
    tv[6] = '{0, 32'h0,  1, 0, 5'd0, 0, 1, 0, 32'h40, 3};
    tv[7] = '{0, 32'h0,  1, 0, 5'd0, 0, 1, 0, 32'h40, 3};
`else
    tv[5] = '{0, 32'h0,  1, 0, 5'd0, 0, 0, 1, 32'h0,  3};
    tv[6] = '{0, 32'h0,  1, 0, 5'd0, 1, 1, 0, 32'h0,  4};
    tv[7] = '{0, 32'h0,  1, 0, 5'd0, 0, 1, 0, 32'h40, 4};
`endif
    for (int i = 0; i < 8; i++) begin
      step(tv[i].iv, tv[i].ins, tv[i].rdy, 1'b0, tv[i].wbv, tv[i].wbrd, o);
      chk($sformatf("tv%0d_valid", i), o.ivalid, tv[i].e_v);
      chk($sformatf("tv%0d_ready", i), o.iready, tv[i].e_r);
      chk($sformatf("tv%0d_stall", i), o.stall, tv[i].e_s);
      chk($sformatf("tv%0d_busy", i), o.busy, tv[i].e_busy);
      chk($sformatf("tv%0d_cnt", i), o.cnt, tv[i].e_cnt);
    end

    // reset while holding an instruction with x5 in flight
    step(1'b1, ADD_X5, 1'b1, 1'b0, 1'b1, 5'd6, o);
    step(1'b1, enc_i(8, 0, 1), 1'b1, 1'b0, 1'b0, 5'd0, o);
    idle(1'b0, o);
    chk("pre_rst_busy", o.busy, 32'h20);
    chk("pre_rst_valid", o.ivalid, 1);
    do_reset();

    // WAW on x7, then an rd=x0 instruction that must never stall
    step(1'b1, LUI_X7, 1'b1, 1'b0, 1'b0, 5'd0, o);
    step(1'b1, ADDI_7, 1'b1, 1'b0, 1'b0, 5'd0, o);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1, o);
      chk("waw_stall", o.stall, 1);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd7, o);
    idle(1'b0, o);
    idle(1'b0, o);
    chk("waw_released", o.ivalid, 1);
    step(1'b1, NOP, 1'b1, 1'b0, 1'b0, 5'd0, o);
    idle(1'b0, o);
    chk("nop_no_stall", o.stall, 0);
    chk("nop_offered", o.ivalid, 1);
    idle(1'b1, o);
    idle(1'b0, o);
    chk("nop_sets_nothing", o.busy, 32'h80);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd7, o);

    // back-to-back stream, then back-pressure holds the last one stable
    for (int k = 0; k < 6; k++) begin
      step(1'b1, enc_i(10 + k, 0, k), 1'b1, 1'b0, 1'b0, 5'd0, o);
      chk("stream_ready", o.iready, 1);
      if (k > 0) chk("stream_valid", o.ivalid, 1);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1'b0, o);
      chk("hold_stable", o.instr, enc_i(15, 0, 5));
    end

    // flush beats fire and accept
    busy_before = o.busy;
    step(1'b1, NOP, 1'b1, 1'b1, 1'b0, 5'd0, o);
    chk("flush_no_accept", o.iready, 0);
    idle(1'b1, o);
    chk("flush_empty", o.ivalid, 0);
    chk("flush_busy_kept", o.busy, busy_before);
    for (int k = 10; k < 16; k++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'(k), o);

    // set beats same-cycle clear on x9, then saturate the stall counter
    step(1'b1, enc_i(9, 0, 1), 1'b1, 1'b0, 1'b0, 5'd0, o);
    step(1'b1, enc_i(1, 9, 0), 1'b1, 1'b0, 1'b1, 5'd9, o);
    idle(1'b1, o);
    chk("set_wins_busy9", o.busy[9], 1);
    chk("dep_on_x9_stalls", o.stall, 1);
    for (int i = 0; i < CNT_MAX + 8; i++) idle(1'b1, o);
    chk("cnt_saturated", o.cnt, CNT_MAX);
    chk("cnt_sat_stall", o.stall, 1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd9, o);
    idle(1'b1, o);
    idle(1'b1, o);
    idle(1'b1, o);
    chk("cnt_no_wrap", o.cnt, CNT_MAX);

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      ins = $urandom;
      ins[6:0]   = ops[$urandom_range(0, 9)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      step(($urandom_range(0, 99) < 70), ins, ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 35),
           5'($urandom_range(0, 7)), o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
